// File: rtl/window5x5_gen.sv
// Streaming 5x5 sliding-window generator: four line buffers plus a 5x5 register
// window, emitting one window per accepted pixel wherever a full neighbourhood exists.
module window5x5_gen #(
  parameter int DATA_BITS = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] pix_in,
  output logic                        valid_out,
  output logic signed [DATA_BITS-1:0] p00, p01, p02, p03, p04,
  output logic signed [DATA_BITS-1:0] p10, p11, p12, p13, p14,
  output logic signed [DATA_BITS-1:0] p20, p21, p22, p23, p24,
  output logic signed [DATA_BITS-1:0] p30, p31, p32, p33, p34,
  output logic signed [DATA_BITS-1:0] p40, p41, p42, p43, p44,
  output logic                        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef logic signed [DATA_BITS-1:0] pix_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_out_q, valid_out_d;
  logic          frame_done_q, frame_done_d;
  logic          last_col, last_row;
  pix_t          win_q [5][5];
  pix_t          win_d [5][5];
  // lb_mem[0] holds row y-1 ... lb_mem[3] holds row y-4; never cleared.
  pix_t          lb_mem [4][IMG_W];

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    last_col     = (col_q == CW'(IMG_W - 1));
    last_row     = (row_q == RW'(IMG_H - 1));
    if (valid_in) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][4]  = lb_mem[3][col_q];
      win_d[1][4]  = lb_mem[2][col_q];
      win_d[2][4]  = lb_mem[1][col_q];
      win_d[3][4]  = lb_mem[0][col_q];
      win_d[4][4]  = pix_in;
      valid_out_d  = (col_q >= CW'(4)) && (row_q >= RW'(4));
      frame_done_d = last_col && last_row;
      col_d        = last_col ? '0 : col_q + 1'b1;
      if (last_col) begin
        row_d = last_row ? '0 : row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Buffers cascade one row older at the current column; a pixel dropped by reset is not stored.
  always_ff @(posedge clk) begin
    if (valid_in && !rst) begin
      lb_mem[3][col_q] <= lb_mem[2][col_q];
      lb_mem[2][col_q] <= lb_mem[1][col_q];
      lb_mem[1][col_q] <= lb_mem[0][col_q];
      lb_mem[0][col_q] <= pix_in;
    end
  end

  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

  assign p00 = win_q[0][0];
  assign p01 = win_q[0][1];
  assign p02 = win_q[0][2];
  assign p03 = win_q[0][3];
  assign p04 = win_q[0][4];
  assign p10 = win_q[1][0];
  assign p11 = win_q[1][1];
  assign p12 = win_q[1][2];
  assign p13 = win_q[1][3];
  assign p14 = win_q[1][4];
  assign p20 = win_q[2][0];
  assign p21 = win_q[2][1];
  assign p22 = win_q[2][2];
  assign p23 = win_q[2][3];
  assign p24 = win_q[2][4];
  assign p30 = win_q[3][0];
  assign p31 = win_q[3][1];
  assign p32 = win_q[3][2];
  assign p33 = win_q[3][3];
  assign p34 = win_q[3][4];
  assign p40 = win_q[4][0];
  assign p41 = win_q[4][1];
  assign p42 = win_q[4][2];
  assign p43 = win_q[4][3];
  assign p44 = win_q[4][4];

endmodule

// File: tb/tb_window5x5_gen.sv
// Directed bench for window5x5_gen: an 8x6 instance for the scenario list and a
// 28x28 instance checked window-by-window against an image-array reference.
module tb_window5x5_gen;

  localparam int W = 8;
  localparam int H = 6;
  localparam int BW = 28;
  localparam int BH = 28;

  logic clk = 1'b0;
  logic rst;
  logic vin, vin2;
  logic signed [7:0] pin, pin2;
  logic signed [7:0] sp [5][5];
  logic signed [7:0] dp [5][5];
  logic vout, fd, vout2, fd2;

  int total = 0;
  int bad = 0;
  int nwin, nwin2, fd_cnt;
  logic signed [7:0] img [H][W];
  logic signed [7:0] img2 [BH][BW];
  logic signed [7:0] fw [5][5];

  always #5 clk = ~clk;

  window5x5_gen #(.DATA_BITS(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .valid_in(vin), .pix_in(pin), .valid_out(vout),
    .p00(sp[0][0]), .p01(sp[0][1]), .p02(sp[0][2]), .p03(sp[0][3]), .p04(sp[0][4]),
    .p10(sp[1][0]), .p11(sp[1][1]), .p12(sp[1][2]), .p13(sp[1][3]), .p14(sp[1][4]),
    .p20(sp[2][0]), .p21(sp[2][1]), .p22(sp[2][2]), .p23(sp[2][3]), .p24(sp[2][4]),
    .p30(sp[3][0]), .p31(sp[3][1]), .p32(sp[3][2]), .p33(sp[3][3]), .p34(sp[3][4]),
    .p40(sp[4][0]), .p41(sp[4][1]), .p42(sp[4][2]), .p43(sp[4][3]), .p44(sp[4][4]),
    .frame_done(fd)
  );

  window5x5_gen #(.DATA_BITS(8), .IMG_W(BW), .IMG_H(BH)) dut_big (
    .clk(clk), .rst(rst), .valid_in(vin2), .pix_in(pin2), .valid_out(vout2),
    .p00(dp[0][0]), .p01(dp[0][1]), .p02(dp[0][2]), .p03(dp[0][3]), .p04(dp[0][4]),
    .p10(dp[1][0]), .p11(dp[1][1]), .p12(dp[1][2]), .p13(dp[1][3]), .p14(dp[1][4]),
    .p20(dp[2][0]), .p21(dp[2][1]), .p22(dp[2][2]), .p23(dp[2][3]), .p24(dp[2][4]),
    .p30(dp[3][0]), .p31(dp[3][1]), .p32(dp[3][2]), .p33(dp[3][3]), .p34(dp[3][4]),
    .p40(dp[4][0]), .p41(dp[4][1]), .p42(dp[4][2]), .p43(dp[4][3]), .p44(dp[4][4]),
    .frame_done(fd2)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int off, input bit sig);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = 8'(8 * y + x + off);
    if (sig) begin
      img[0][0] = 8'sd127;
      img[4][4] = -8'sd128;
    end
  endtask

  // Drive one pixel (after `gap` idle cycles) and check the registered result.
  task automatic pix(input int x, input int y, input int gap);
    logic signed [7:0] h00, h44;
    for (int g = 0; g < gap; g++) begin
      h00 = sp[0][0];
      h44 = sp[4][4];
      vin = 1'b0;
      pin = 8'sh55;
      @(posedge clk); #1;
      chk("gap_vout", vout, 0);
      chk("gap_fd", fd, 0);
      chk("gap_hold_p00", sp[0][0], h00);
      chk("gap_hold_p44", sp[4][4], h44);
    end
    vin = 1'b1;
    pin = img[y][x];
    @(posedge clk); #1;
    vin = 1'b0;
    chk("vout", vout, (x >= 4 && y >= 4) ? 1 : 0);
    chk("fd", fd, (x == W - 1 && y == H - 1) ? 1 : 0);
    if (fd === 1'b1) fd_cnt++;
    if (x >= 4 && y >= 4) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          chk($sformatf("win(%0d,%0d)p%0d%0d", x, y, r, c), sp[r][c], img[y-4+r][x-4+c]);
      if (nwin == 0) fw = sp;
      nwin++;
    end
  endtask

  task automatic frame(input bit gaps);
    nwin = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pix(x, y, gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vout"}, vout, 0);
    chk({tag, "_fd"}, fd, 0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        chk($sformatf("%s_p%0d%0d", tag, r, c), sp[r][c], 0);
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; pin = '0; vin2 = 1'b0; pin2 = '0;
    fd_cnt = 0; nwin = 0; nwin2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Scenario 1: single contiguous frame.
    fill(0, 1'b0);
    fd_cnt = 0;
    frame(1'b0);
    chk("s1_nwin", nwin, 8);
    chk("s1_first_p00", fw[0][0], 0);
    chk("s1_first_p04", fw[0][4], 4);
    chk("s1_first_p40", fw[4][0], 32);
    chk("s1_first_p44", fw[4][4], 36);
    chk("s1_first_p22", fw[2][2], 18);
    chk("s1_last_p00", sp[0][0], 11);
    chk("s1_last_p44", sp[4][4], 47);
    chk("s1_fd_cnt", fd_cnt, 1);

    // Scenario 2: random gaps.
    frame(1'b1);
    chk("s2_nwin", nwin, 8);
    chk("s2_last_p00", sp[0][0], 11);

    // Scenario 3: back-to-back frames, second offset by 50.
    fd_cnt = 0;
    frame(1'b0);
    fill(50, 1'b0);
    frame(1'b0);
    chk("s3_nwin", nwin, 8);
    chk("s3_first_p00", fw[0][0], 50);
    chk("s3_first_p44", fw[4][4], 86);
    chk("s3_fd_cnt", fd_cnt, 2);

    // Scenario 4: reset after pixel (3,3), with a pixel offered during reset.
    fill(0, 1'b0);
    nwin = 0;
    for (int i = 0; i <= 3 * W + 3; i++) pix(i % W, i / W, 0);
    rst = 1'b1; vin = 1'b1; pin = 8'sd99;
    @(posedge clk); #1;
    chk_zero("s4_rst1");
    @(posedge clk); #1;
    chk_zero("s4_rst2");
    rst = 1'b0; vin = 1'b0;
    frame(1'b0);
    chk("s4_nwin", nwin, 8);
    chk("s4_first_p44", fw[4][4], 36);
    chk("s4_last_p44", sp[4][4], 47);

    // Scenario 5: signed extremes.
    fill(0, 1'b1);
    frame(1'b0);
    chk("s5_first_p44", fw[4][4], -128);
    chk("s5_first_p00", fw[0][0], 127);

    // Scenario 6: 28x28 ramp on the default-size instance.
    for (int y = 0; y < BH; y++)
      for (int x = 0; x < BW; x++)
        img2[y][x] = 8'(BW * y + x);
    nwin2 = 0;
    fd_cnt = 0;
    for (int y = 0; y < BH; y++) begin
      for (int x = 0; x < BW; x++) begin
        vin2 = 1'b1;
        pin2 = img2[y][x];
        @(posedge clk); #1;
        vin2 = 1'b0;
        chk("big_vout", vout2, (x >= 4 && y >= 4) ? 1 : 0);
        chk("big_fd", fd2, (x == BW - 1 && y == BH - 1) ? 1 : 0);
        if (fd2 === 1'b1) fd_cnt++;
        if (x >= 4 && y >= 4) begin
          nwin2++;
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              chk($sformatf("big(%0d,%0d)p%0d%0d", x, y, r, c), dp[r][c], img2[y-4+r][x-4+c]);
        end
      end
    end
    chk("big_nwin", nwin2, 576);
    chk("big_fd_cnt", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
